// File: rtl/multichannel_gain_pkg.sv
// Shared types and constant helpers for the multichannel gain stage.
package multichannel_gain_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Constants are built wide and truncated by the caller to the real width.
  localparam int CONST_W = 128;

  function automatic logic [CONST_W-1:0] unity_gain(input int frac_bits);
    return CONST_W'(1) << frac_bits;
  endfunction

  function automatic logic [CONST_W-1:0] sample_max(input int data_size);
    return (CONST_W'(1) << (data_size - 1)) - CONST_W'(1);
  endfunction

  function automatic logic [CONST_W-1:0] sample_min(input int data_size);
    return ~sample_max(data_size);
  endfunction

  function automatic int sel_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/multichannel_gain_if.sv
// FIFO-side streams plus gain/mute/clip control of the multichannel gain stage.
interface multichannel_gain_if
  import multichannel_gain_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int GAIN_BITS    = 16,
  parameter int SEL_W        = sel_width(NUM_CHANNELS)
) ();

  logic [NUM_CHANNELS-1:0]           x_in_empty;
  logic [NUM_CHANNELS-1:0]           x_in_rd_en;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] x_in_dout;
  logic [NUM_CHANNELS-1:0]           y_out_full;
  logic [NUM_CHANNELS-1:0]           y_out_wr_en;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] y_out_din;
  logic                              gain_wr_en;
  logic [SEL_W-1:0]                  gain_sel;
  logic [GAIN_BITS-1:0]              gain_din;
  logic                              mute;
  logic [NUM_CHANNELS-1:0]           clip;
  logic                              clip_clr;

  modport master (
    output x_in_empty, x_in_dout, y_out_full,
    output gain_wr_en, gain_sel, gain_din, mute, clip_clr,
    input  x_in_rd_en, y_out_wr_en, y_out_din, clip
  );

  modport slave (
    input  x_in_empty, x_in_dout, y_out_full,
    input  gain_wr_en, gain_sel, gain_din, mute, clip_clr,
    output x_in_rd_en, y_out_wr_en, y_out_din, clip
  );

endinterface

// File: rtl/gain_scale_sat.sv
// One channel: capture sample+gain, registered multiply/shift, then
// saturate (or wrap) with sticky clip detection on the write cycle.
module gain_scale_sat
  import multichannel_gain_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int GAIN_BITS = 16,
  parameter int FRAC_BITS = 10,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 mul_i,
  input  logic                 wr_i,
  input  logic                 mute_i,
  input  logic                 clip_clr_i,
  input  logic [DATA_SIZE-1:0] x_i,
  input  logic [GAIN_BITS-1:0] gain_i,
  output logic [DATA_SIZE-1:0] y_o,
  output logic                 clip_o
);

  localparam int PW = DATA_SIZE + GAIN_BITS + 1;
  localparam logic [DATA_SIZE-1:0] SMAX = DATA_SIZE'(sample_max(DATA_SIZE));
  localparam logic [DATA_SIZE-1:0] SMIN = DATA_SIZE'(sample_min(DATA_SIZE));

  logic [DATA_SIZE-1:0] x_q, x_d;
  logic [GAIN_BITS-1:0] g_q, g_d;
  logic signed [PW-1:0] xe, ge, p, r_q, r_d;
  logic [DATA_SIZE-1:0] y_q, y_d, y_sat;
  logic                 ovf, clip_q, clip_d;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign xe = {{(GAIN_BITS+1){x_q[DATA_SIZE-1]}}, x_q};
  assign ge = {{(DATA_SIZE+1){1'b0}}, g_q};
  assign p  = xe * ge;

  // Overflow when the bits above the result's sign bit are not a pure sign extension.
  assign ovf = ~((&r_q[PW-1:DATA_SIZE-1]) | ~(|r_q[PW-1:DATA_SIZE-1]));

  always_comb begin
    x_d = load_i ? x_i : x_q;
    g_d = load_i ? gain_i : g_q;
    r_d = mul_i ? (p >>> FRAC_BITS) : r_q;

    y_sat = r_q[DATA_SIZE-1:0];
    if (SATURATE && ovf) y_sat = r_q[PW-1] ? SMIN : SMAX;

    y_d = y_q;
    if (wr_i) y_d = mute_i ? '0 : y_sat;

    clip_d = clip_q;
    if (clip_clr_i) clip_d = 1'b0;
    if (wr_i && !mute_i && ovf) clip_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q    <= '0;
      g_q    <= '0;
      r_q    <= '0;
      y_q    <= '0;
      clip_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      g_q    <= g_d;
      r_q    <= r_d;
      y_q    <= y_d;
      clip_q <= clip_d;
    end
  end

  assign y_o    = y_d;
  assign clip_o = clip_q;

endmodule

// File: rtl/multichannel_gain.sv
// Lockstep per-channel programmable gain: FSM and gain registers here,
// arithmetic in one gain_scale_sat per channel.
module multichannel_gain
  import multichannel_gain_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int GAIN_BITS    = 16,
  parameter int FRAC_BITS    = 10,
  parameter bit SATURATE     = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  multichannel_gain_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_CHANNELS);
  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(unity_gain(FRAC_BITS));

  state_t state_q, state_d;
  logic   frame_rdy, rd, mul, wr;
  logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0] y_w;
  logic [NUM_CHANNELS-1:0]                clip_w;

  // A frame starts only when every input has data and every output has room.
  assign frame_rdy = ~(|bus.x_in_empty) & ~(|bus.y_out_full);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_rdy) state_d = S_MUL;
      S_MUL:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are masked while reset is held so no FIFO is touched in reset.
  always_comb begin
    rd  = 1'b0;
    mul = 1'b0;
    wr  = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE:  rd  = frame_rdy;
        S_MUL:   mul = 1'b1;
        S_WRITE: wr  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.x_in_rd_en  = {NUM_CHANNELS{rd}};
  assign bus.y_out_wr_en = {NUM_CHANNELS{wr}};
  assign bus.clip        = clip_w;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    logic [GAIN_BITS-1:0] gain_q;

    // Out-of-range selects never match any lane and are dropped.
    always_ff @(posedge clock) begin
      if (!reset)
        gain_q <= UNITY;
      else if (bus.gain_wr_en && (bus.gain_sel == SEL_W'(c)))
        gain_q <= bus.gain_din;
    end

    gain_scale_sat #(
      .DATA_SIZE (DATA_SIZE),
      .GAIN_BITS (GAIN_BITS),
      .FRAC_BITS (FRAC_BITS),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .load_i     (rd),
      .mul_i      (mul),
      .wr_i       (wr),
      .mute_i     (bus.mute),
      .clip_clr_i (bus.clip_clr),
      .x_i        (bus.x_in_dout[c*DATA_SIZE +: DATA_SIZE]),
      .gain_i     (gain_q),
      .y_o        (y_w[c]),
      .clip_o     (clip_w[c])
    );

    assign bus.y_out_din[c*DATA_SIZE +: DATA_SIZE] = y_w[c];
  end

endmodule

// File: tb/tb_multichannel_gain.sv
// Directed bench for multichannel_gain: vector table plus hand-written corner sequences.
module tb_multichannel_gain;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multichannel_gain_if #(.DATA_SIZE(32), .NUM_CHANNELS(2), .GAIN_BITS(16)) bus ();

  multichannel_gain #(
    .DATA_SIZE(32), .NUM_CHANNELS(2), .GAIN_BITS(16), .FRAC_BITS(10), .SATURATE(1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          wg;
    logic [15:0] g0, g1;
    logic [31:0] x0, x1;
    bit          m;
    logic [31:0] e0, e1;
    logic [1:0]  ec;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_gain(input logic sel, input logic [15:0] val);
    @(negedge clock);
    bus.gain_wr_en = 1'b1;
    bus.gain_sel   = sel;
    bus.gain_din   = val;
    @(negedge clock);
    bus.gain_wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    bus.clip_clr = 1'b1;
    @(negedge clock);
    bus.clip_clr = 1'b0;
  endtask

  // Offers one frame, optionally writes gain ch0 in the read cycle, returns outputs and rd->wr latency.
  task automatic frame(input logic [31:0] a, input logic [31:0] b, input bit m,
                       input bit gw, input logic [15:0] gv,
                       output logic [31:0] y0, output logic [31:0] y1, output int lat);
    int n;
    y0  = '0;
    y1  = '0;
    lat = -1;
    @(negedge clock);
    bus.x_in_dout  = {b, a};
    bus.x_in_empty = 2'b00;
    bus.y_out_full = 2'b00;
    bus.mute       = m;
    #1;
    n = 0;
    while (bus.x_in_rd_en !== 2'b11 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (bus.x_in_rd_en !== 2'b11) begin
      checks++; errors++;
      $display("FAIL rd_en timeout: got %0b required 11", bus.x_in_rd_en);
      bus.x_in_empty = 2'b11;
      bus.mute       = 1'b0;
      return;
    end
    if (gw) begin
      bus.gain_wr_en = 1'b1;
      bus.gain_sel   = 1'b0;
      bus.gain_din   = gv;
    end
    @(posedge clock); #1;
    bus.x_in_empty = 2'b11;
    bus.gain_wr_en = 1'b0;
    lat = 0;
    while (bus.y_out_wr_en !== 2'b11 && lat < 10) begin
      @(negedge clock); lat++;
    end
    y0 = bus.y_out_din[31:0];
    y1 = bus.y_out_din[63:32];
    @(posedge clock); #1;
    bus.mute = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] y0, y1;
    int lat, bad;

    vt[0] = '{0, 16'd0,     16'd0,    32'h00001000, 32'hFFFFF000, 0, 32'h00001000, 32'hFFFFF000, 2'b00};
    vt[1] = '{1, 16'd2048,  16'd512,  32'h00001000, 32'hFFFFF000, 0, 32'h00002000, 32'hFFFFF800, 2'b00};
    vt[2] = '{1, 16'd2048,  16'd4096, 32'h7FFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF, 32'h80000000, 2'b11};
    vt[3] = '{1, 16'd2048,  16'd4096, 32'h7FFFFFFF, 32'h80000000, 1, 32'h00000000, 32'h00000000, 2'b00};
    vt[4] = '{1, 16'd1,     16'd512,  32'h00000003, 32'hFFFFFFFF, 0, 32'h00000000, 32'hFFFFFFFF, 2'b00};
    vt[5] = '{1, 16'd65535, 16'd0,    32'h00000001, 32'h12345678, 0, 32'h0000003F, 32'h00000000, 2'b00};
    vt[6] = '{1, 16'd2048,  16'd2048, 32'hC0000000, 32'hBFFFFFFF, 0, 32'h80000000, 32'h80000000, 2'b10};

    reset          = 1'b0;
    bus.x_in_empty = 2'b00;
    bus.y_out_full = 2'b00;
    bus.x_in_dout  = {32'hFFFFF000, 32'h00001000};
    bus.gain_wr_en = 1'b0;
    bus.gain_sel   = 1'b0;
    bus.gain_din   = '0;
    bus.mute       = 1'b0;
    bus.clip_clr   = 1'b0;

    // Reset held with data available: nothing may move.
    repeat (3) @(negedge clock);
    #1;
    chk("reset rd_en", bus.x_in_rd_en, 2'b00);
    chk("reset wr_en", bus.y_out_wr_en, 2'b00);
    chk("reset y_out_din", bus.y_out_din, 64'h0);
    chk("reset clip", bus.clip, 2'b00);
    bus.x_in_empty = 2'b11;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vt[i].wg) begin
        set_gain(1'b0, vt[i].g0);
        set_gain(1'b1, vt[i].g1);
      end
      pulse_clr();
      frame(vt[i].x0, vt[i].x1, vt[i].m, 1'b0, 16'd0, y0, y1, lat);
      chk($sformatf("v%0d y0", i), y0, vt[i].e0);
      chk($sformatf("v%0d y1", i), y1, vt[i].e1);
      chk($sformatf("v%0d latency", i), lat, 2);
      chk($sformatf("v%0d clip", i), bus.clip, vt[i].ec);
    end

    // Gains 2048/2048, clip=10: mute must zero data and leave clip alone.
    frame(32'h7FFFFFFF, 32'h00000200, 1'b1, 1'b0, 16'd0, y0, y1, lat);
    chk("mute y0", y0, 32'h0);
    chk("mute y1", y1, 32'h0);
    chk("mute clip kept", bus.clip, 2'b10);

    frame(32'h7FFFFFFF, 32'hBFFFFFFF, 1'b0, 1'b0, 16'd0, y0, y1, lat);
    chk("ovf y0", y0, 32'h7FFFFFFF);
    chk("ovf y1", y1, 32'h80000000);
    chk("clip accumulate", bus.clip, 2'b11);
    repeat (3) @(negedge clock);
    chk("hold y_out_din", bus.y_out_din, {32'h80000000, 32'h7FFFFFFF});
    chk("hold wr_en", bus.y_out_wr_en, 2'b00);
    pulse_clr();
    #1;
    chk("clip_clr", bus.clip, 2'b00);

    // Clear held through the write cycle: the set must win.
    @(negedge clock);
    bus.clip_clr = 1'b1;
    frame(32'h7FFFFFFF, 32'hBFFFFFFF, 1'b0, 1'b0, 16'd0, y0, y1, lat);
    chk("set beats clr", bus.clip, 2'b11);
    bus.clip_clr = 1'b0;
    pulse_clr();

    // Stalls: one channel empty, then one output full.
    set_gain(1'b0, 16'd1024);
    set_gain(1'b1, 16'd1024);
    @(negedge clock);
    bus.x_in_dout  = {32'hFFFFF000, 32'h00001000};
    bus.x_in_empty = 2'b10;
    bad = 0;
    repeat (20) begin
      @(negedge clock); #1;
      if (bus.x_in_rd_en !== 2'b00 || bus.y_out_wr_en !== 2'b00) bad = 1;
    end
    chk("stall partial empty", bad, 0);
    bus.x_in_empty = 2'b00;
    bus.y_out_full = 2'b01;
    bad = 0;
    repeat (20) begin
      @(negedge clock); #1;
      if (bus.x_in_rd_en !== 2'b00 || bus.y_out_wr_en !== 2'b00) bad = 1;
    end
    chk("stall full", bad, 0);
    frame(32'h00001000, 32'hFFFFF000, 1'b0, 1'b0, 16'd0, y0, y1, lat);
    chk("release y0", y0, 32'h00001000);
    chk("release y1", y1, 32'hFFFFF000);
    chk("release latency", lat, 2);

    // Gain write landing on the snapshot edge belongs to the next frame.
    frame(32'h00001000, 32'hFFFFF000, 1'b0, 1'b1, 16'd2048, y0, y1, lat);
    chk("snapshot same frame y0", y0, 32'h00001000);
    frame(32'h00001000, 32'hFFFFF000, 1'b0, 1'b0, 16'd0, y0, y1, lat);
    chk("snapshot next frame y0", y0, 32'h00002000);
    chk("snapshot next frame y1", y1, 32'hFFFFF000);

    // Reset in S_MUL: frame dropped, gains back to unity.
    set_gain(1'b1, 16'd512);
    @(negedge clock);
    bus.x_in_dout  = {32'hFFFFF000, 32'h00001000};
    bus.x_in_empty = 2'b00;
    #1;
    chk("pre-reset rd_en", bus.x_in_rd_en, 2'b11);
    @(posedge clock); #1;
    bus.x_in_empty = 2'b11;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.y_out_wr_en !== 2'b00) bad = 1;
    end
    chk("no write after reset", bad, 0);
    chk("y_out_din after reset", bus.y_out_din, 64'h0);
    frame(32'h00001000, 32'hFFFFF000, 1'b0, 1'b0, 16'd0, y0, y1, lat);
    chk("post-reset y0", y0, 32'h00001000);
    chk("post-reset y1", y1, 32'hFFFFF000);
    chk("post-reset latency", lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
